// File: rtl/aes_input_interface_pkg.sv
// ----------------------------------------------------------------------------
// aes_if_pkg
// Shared definitions for the AES byte-serial input front end.
//  - BLOCK_BYTES / LAST_BYTE_IDX : AES-128 block geometry.
//  - state_e                     : 2-bit FSM encoding (IDLE, PEND, ISSUE, WAIT).
//  - shift_in_byte()             : MSB-first byte order shared with the output
//                                  stage. The first byte of a block ends up in
//                                  bits [127:120].
// ----------------------------------------------------------------------------
package aes_if_pkg;

    localparam int         BLOCK_BYTES   = 16;
    localparam logic [4:0] LAST_BYTE_IDX = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    // Older bytes move toward the MSB. After 16 shifts, byte 0 is in [127:120].
    function automatic logic [127:0] shift_in_byte(input logic [127:0] blk,
                                                   input logic [7:0]   b);
        return {blk[119:0], b};
    endfunction

endpackage

// File: rtl/aes_input_interface_if.sv
// ----------------------------------------------------------------------------
// aes_input_interface_if
// Byte-input and block-output bundle of the AES input front end.
//  master : byte source / output stage / round transformer side.
//  slave  : aes_input_interface itself.
// ----------------------------------------------------------------------------
interface aes_input_interface_if;

    logic [7:0]   data_in;
    logic         data_valid;
    logic         key_sel;
    logic         output_read;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         key_valid;
    logic         start;
    logic         busy;

    modport master (
        output data_in, data_valid, key_sel, output_read,
        input  in_ready, plaintext, key, key_valid, start, busy
    );

    modport slave (
        input  data_in, data_valid, key_sel, output_read,
        output in_ready, plaintext, key, key_valid, start, busy
    );

endinterface

// File: rtl/aes_byte_collector.sv
// ----------------------------------------------------------------------------
// aes_byte_collector
// Assembles accepted bytes into 128-bit blocks and tracks which stream
// (key or plaintext) the current partial block belongs to.
//  clk, rst_        : clock, asynchronous active-low reset
//  byte_i           : input byte
//  accept_i         : byte_i is consumed this cycle
//  key_sel_i        : stream of byte_i (1 = key)
//  block_done_o     : this accepted byte completes a block (combinational)
//  block_is_key_o   : stream of the completing block
//  block_o          : the completed block, valid with block_done_o
// ----------------------------------------------------------------------------
module aes_byte_collector
    import aes_if_pkg::*;
(
    input  logic         clk,
    input  logic         rst_,
    input  logic [7:0]   byte_i,
    input  logic         accept_i,
    input  logic         key_sel_i,
    output logic         block_done_o,
    output logic         block_is_key_o,
    output logic [127:0] block_o
);

    logic [127:0] sr_q,  sr_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         sel_q, sel_d;
    logic         done_s;

    // Collector state register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sr_q  <= 128'd0;
            cnt_q <= 5'd0;
            sel_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    // Byte counting, stream tracking and mixed-stream restart.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        done_s = 1'b0;
        if (accept_i) begin
            sr_d = shift_in_byte(sr_q, byte_i);
            // A first byte, or a byte from the other stream, opens a new block.
            // The stale partial bytes left in sr are shifted out before completion.
            if ((cnt_q == 5'd0) || (key_sel_i != sel_q)) begin
                cnt_d = 5'd1;
                sel_d = key_sel_i;
            end else if (cnt_q == LAST_BYTE_IDX) begin
                cnt_d  = 5'd0;
                done_s = 1'b1;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    assign block_done_o   = done_s;
    assign block_is_key_o = sel_q;
    assign block_o        = shift_in_byte(sr_q, byte_i);

endmodule

// File: rtl/aes_input_interface.sv
// ----------------------------------------------------------------------------
// aes_input_interface
// Byte-serial front end of the AES engine. It collects 16-byte key and
// plaintext blocks and issues a one-cycle start once both are held. Further
// input is blocked until the output stage reports readout.
//  clk  : system clock
//  rst_ : asynchronous active-low reset
//  bus  : aes_input_interface_if.slave, which carries data_in, data_valid,
//         key_sel, output_read, in_ready, plaintext, key, key_valid, start
//         and busy.
// ----------------------------------------------------------------------------
module aes_input_interface
    import aes_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_,
    aes_input_interface_if.slave  bus
);

    state_e       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         start_q, start_d;
    logic         busy_q, busy_d;
    logic         key_valid_q, key_valid_d;
    logic [127:0] key_q, key_d;
    logic [127:0] pt_q, pt_d;

    logic         in_ready_s;
    logic         accept_s;
    logic         blk_done_s;
    logic         blk_is_key_s;
    logic [127:0] blk_s;

    // In PEND only key bytes pass, so in_ready follows key_sel combinationally.
    assign in_ready_s = (state_q == ST_PEND) ? bus.key_sel : in_ready_q;
    assign accept_s   = bus.data_valid & in_ready_s;

    aes_byte_collector u_collector (
        .clk            (clk),
        .rst_           (rst_),
        .byte_i         (bus.data_in),
        .accept_i       (accept_s),
        .key_sel_i      (bus.key_sel),
        .block_done_o   (blk_done_s),
        .block_is_key_o (blk_is_key_s),
        .block_o        (blk_s)
    );

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_q       <= 128'd0;
            pt_q        <= 128'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            key_valid_q <= key_valid_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (blk_done_s && !blk_is_key_s) begin
                    state_d = key_valid_q ? ST_ISSUE : ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (blk_done_s && blk_is_key_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.output_read) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs are derived from the next state so they register in step with it.
    always_comb begin
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_PEND);
        start_d    = (state_d == ST_ISSUE);
        busy_d     = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    end

    // Block latching. No bytes are accepted while busy, so key and plaintext stay stable under the engine.
    always_comb begin
        key_d       = key_q;
        pt_d        = pt_q;
        key_valid_d = key_valid_q;
        if (blk_done_s) begin
            if (blk_is_key_s) begin
                key_d       = blk_s;
                key_valid_d = 1'b1;
            end else begin
                pt_d = blk_s;
            end
        end else begin
            key_d = key_q;
            pt_d  = pt_q;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.plaintext = pt_q;
    assign bus.key       = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.start     = start_q;
    assign bus.busy      = busy_q;

endmodule
